// File: rtl/bus_arbiter_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bus_arbiter_n
// Brief   : N-master bus arbiter, fixed-priority or round-robin, optional hold limit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module bus_arbiter_n #(
    parameter  int NUM_M    = 3,
    parameter  int RR_MODE  = 0,
    parameter  int MAX_HOLD = 0,
    localparam int IDW      = (NUM_M <= 2) ? 1 : $clog2(NUM_M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grnt,
    output logic [IDW-1:0]   grnt_id,
    output logic             grnt_vld
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] c_max      = HW'(MAX_HOLD);
    localparam logic [HW-1:0] c_hold_lim = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_M-1:0]   r_grnt, w_grnt_nxt;
    logic [IDW-1:0]     r_id, w_id_nxt;
    logic               r_vld, w_vld_nxt;
    logic [HW-1:0]      r_cnt, w_cnt_nxt;
    logic [IDW-1:0]     r_last, w_last_nxt;

    logic               w_own_req;
    logic               w_others;
    logic               w_expire;
    logic               w_arb;
    logic [NUM_M-1:0]   w_cand;
    int                 w_start;
    logic [IDW:0]       w_pick;

    // Returns {found, index} of the first set bit of cand scanning upward from start.
    function automatic logic [IDW:0] f_pick(input logic [NUM_M-1:0] cand, input int start);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            idx = start + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (cand[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        w_own_req = |(req & r_grnt);
        w_others  = |(req & ~r_grnt);
        w_expire  = (MAX_HOLD > 0) && (r_state == S_BUSY) && w_own_req &&
                    w_others && (r_cnt >= c_hold_lim);
        w_arb     = (r_state == S_IDLE) || !w_own_req || w_expire;
        w_cand    = w_expire ? (req & ~r_grnt) : req;
        w_start   = (RR_MODE != 0) ? ((int'(r_last) + 1) % NUM_M) : 0;
        w_pick    = f_pick(w_cand, w_start);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grnt_nxt  = r_grnt;
        w_id_nxt    = r_id;
        w_vld_nxt   = r_vld;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        if (w_arb) begin
            if (w_pick[IDW]) begin
                // Arbitration never re-selects the current owner, so any win is an ownership change.
                w_state_nxt = S_BUSY;
                w_grnt_nxt  = NUM_M'(1) << w_pick[IDW-1:0];
                w_id_nxt    = w_pick[IDW-1:0];
                w_vld_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_last_nxt  = w_pick[IDW-1:0];
            end else begin
                w_state_nxt = S_IDLE;
                w_grnt_nxt  = '0;
                w_id_nxt    = '0;
                w_vld_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
        end else if ((MAX_HOLD > 0) && (r_cnt < c_max)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grnt  <= '0;
            r_id    <= '0;
            r_vld   <= 1'b0;
            r_cnt   <= '0;
            r_last  <= IDW'(NUM_M - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grnt  <= w_grnt_nxt;
            r_id    <= w_id_nxt;
            r_vld   <= w_vld_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign grnt     = r_grnt;
    assign grnt_id  = r_id;
    assign grnt_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_bus_arbiter_n
// Brief   : Directed self-checking bench for bus_arbiter_n in four configurations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bus_arbiter_n;

    logic       clk;
    logic       rst_n;

    logic [2:0] req0, grnt0;  logic [1:0] id0;  logic vld0;
    logic [2:0] req1, grnt1;  logic [1:0] id1;  logic vld1;
    logic [2:0] req2, grnt2;  logic [1:0] id2;  logic vld2;
    logic [4:0] req3, grnt3;  logic [2:0] id3;  logic vld3;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_n #(.NUM_M(3), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req0), .grnt(grnt0), .grnt_id(id0), .grnt_vld(vld0));
    bus_arbiter_n #(.NUM_M(3), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req1), .grnt(grnt1), .grnt_id(id1), .grnt_vld(vld1));
    bus_arbiter_n #(.NUM_M(3), .RR_MODE(1), .MAX_HOLD(4)) u_hold (
        .clk(clk), .rst_n(rst_n), .req(req2), .grnt(grnt2), .grnt_id(id2), .grnt_vld(vld2));
    bus_arbiter_n #(.NUM_M(5), .RR_MODE(1), .MAX_HOLD(0)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req3), .grnt(grnt3), .grnt_id(id3), .grnt_vld(vld3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = '0; req1 = '0; req2 = '0; req3 = '0;
        step(); step();

        check("rst_grnt0", 32'(grnt0), 32'd0);
        check("rst_vld0",  32'(vld0),  32'd0);
        check("rst_id0",   32'(id0),   32'd0);
        check("rst_grnt3", 32'(grnt3), 32'd0);
        rst_n = 1'b1;

        // Fixed priority: lowest index wins, no preemption, hand-over on drop.
        req0 = 3'b110; step();
        check("fix_first",  32'(grnt0), 32'b010);
        check("fix_id",     32'(id0),   32'd1);
        check("fix_vld",    32'(vld0),  32'd1);
        step(); step(); step();
        check("fix_hold",   32'(grnt0), 32'b010);
        req0 = 3'b100; step();
        check("fix_switch", 32'(grnt0), 32'b100);
        check("fix_id2",    32'(id0),   32'd2);
        req0 = 3'b101; step();
        check("fix_nopre",  32'(grnt0), 32'b100);
        req0 = 3'b001; step();
        check("fix_to0",    32'(grnt0), 32'b001);
        req0 = 3'b000; step();
        check("fix_idle",   32'(grnt0), 32'd0);
        check("fix_idlev",  32'(vld0),  32'd0);
        check("fix_idlei",  32'(id0),   32'd0);

        // Round-robin: order 0,1,2,0 with no idle gap.
        req1 = 3'b111; step();
        check("rr_o0a", 32'(grnt1), 32'b001);
        step();
        check("rr_o0b", 32'(grnt1), 32'b001);
        req1 = 3'b110; step();
        check("rr_o1a", 32'(grnt1), 32'b010);
        check("rr_v1",  32'(vld1),  32'd1);
        req1 = 3'b111; step();
        check("rr_o1b", 32'(grnt1), 32'b010);
        req1 = 3'b101; step();
        check("rr_o2a", 32'(grnt1), 32'b100);
        check("rr_id2", 32'(id1),   32'd2);
        req1 = 3'b111; step();
        check("rr_o2b", 32'(grnt1), 32'b100);
        req1 = 3'b011; step();
        check("rr_o0c", 32'(grnt1), 32'b001);
        req1 = 3'b110; step();
        check("rr_pre", 32'(grnt1), 32'b010);

        // Asynchronous reset mid-cycle while master 1 owns the bus.
        req1 = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        check("arst_grnt", 32'(grnt1), 32'd0);
        check("arst_vld",  32'(vld1),  32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_first", 32'(grnt1), 32'b001);
        check("arst_id",    32'(id1),   32'd0);
        req1 = 3'b000; step();
        check("rr_idle", 32'(vld1), 32'd0);

        // Hold limit 4: owners alternate every four cycles.
        req2 = 3'b011;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("hold_c%0d", i), 32'(grnt2), ((i / 4) % 2 == 0) ? 32'b001 : 32'b010);
        end
        req2 = 3'b000; step();
        check("hold_idle", 32'(grnt2), 32'd0);
        req2 = 3'b100;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("solo_c%0d", i), 32'(grnt2), 32'b100);
        end
        req2 = 3'b000; step();
        check("solo_idle", 32'(vld2), 32'd0);

        // Five masters: wrap-around of the round-robin pointer.
        req3 = 5'b10000; step();
        check("m5_own4", 32'(id3),   32'd4);
        req3 = 5'b00011; step();
        check("m5_wrap", 32'(id3),   32'd0);
        check("m5_grnt", 32'(grnt3), 32'b00001);
        req3 = 5'b00000; step();
        req3 = 5'b01010; step();
        check("m5_own1", 32'(id3),   32'd1);
        req3 = 5'b01000; step();
        check("m5_own3", 32'(id3),   32'd3);
        req3 = 5'b00101; step();
        check("m5_wrap2", 32'(id3),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
